// File: rtl/i2s_frame_fifo.sv
// i2s_frame_fifo: pairs incoming I2S left/right samples into stereo frames
// and queues them in a first-word-fall-through FIFO with sticky overflow.
// Optional feature macro: I2S_FRAME_FIFO_DROP_COUNT_EN adds a 16-bit
// saturating drop_count output (rejected frames plus orphan right samples).
module i2s_frame_fifo #(
    parameter int I2S_WIDTH  = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          sample_valid,
    input  logic [I2S_WIDTH-1:0]          sample_data,
    input  logic                          sample_lr,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic [I2S_WIDTH-1:0]          frame_left,
    output logic [I2S_WIDTH-1:0]          frame_right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_overflow
`ifdef I2S_FRAME_FIFO_DROP_COUNT_EN
    ,
    output logic [15:0]                   drop_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic {
        WAIT_L,
        WAIT_R
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic                     push_req;
    logic                     latch_load;
    logic                     push_ok;
    logic                     pop;
    logic                     drop;
    logic [I2S_WIDTH-1:0]     left_latch;
    logic [2*I2S_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW-1:0]            rd_next;
    logic [LW-1:0]            level_after_pop;

    // Handshake decode: pop only with data present, push only with room
    // (a full FIFO still accepts when the head leaves in the same cycle).
    always_comb begin
        pop             = (fifo_level != '0) && frame_ready;
        push_ok         = push_req && ((fifo_level < DEPTH_L) || pop);
        drop            = push_req && !push_ok;
        rd_next         = rd_ptr + AW'(pop);
        level_after_pop = fifo_level - LW'(pop);
    end

    assign frame_valid = (fifo_level != '0);

    // Pairing FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= WAIT_L;
        end else begin
            state <= state_next;
        end
    end

    // Pairing FSM next-state and strobes; a left sample always (re)loads the latch.
    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        latch_load = 1'b0;
        case (state)
            WAIT_L: begin
                if (sample_valid && !sample_lr) begin
                    latch_load = 1'b1;
                    state_next = WAIT_R;
                end
            end
            WAIT_R: begin
                if (sample_valid) begin
                    if (sample_lr) begin
                        push_req   = 1'b1;
                        state_next = WAIT_L;
                    end else begin
                        latch_load = 1'b1;
                    end
                end
            end
            default: state_next = WAIT_L;
        endcase
    end

    // Left sample holding register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            left_latch <= '0;
        end else if (latch_load) begin
            left_latch <= sample_data;
        end
    end

    // Frame storage; no reset needed since pointers/level gate visibility.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && push_ok) begin
            mem[wr_ptr] <= {left_latch, sample_data};
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Registered head frame: the head after this edge comes from storage
    // unless the FIFO is (or becomes) empty, where the incoming frame is
    // bypassed in; with nothing to show the last value is held.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_left  <= '0;
            frame_right <= '0;
        end else if (level_after_pop != '0) begin
            {frame_left, frame_right} <= mem[rd_next];
        end else if (push_ok) begin
            frame_left  <= left_latch;
            frame_right <= sample_data;
        end
    end

    // Sticky overflow; a new drop wins over a coincident clear.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef I2S_FRAME_FIFO_DROP_COUNT_EN
    logic orphan;
    logic drop_inc;

    assign orphan   = (state == WAIT_L) && sample_valid && sample_lr;
    assign drop_inc = drop || orphan;

    // Saturating drop counter; clear plus a coincident increment yields 1.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            drop_count <= '0;
        end else if (clear_overflow) begin
            drop_count <= drop_inc ? 16'd1 : 16'd0;
        end else if (drop_inc && (drop_count != '1)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_frame_fifo.sv
// tb_i2s_frame_fifo: directed self-checking bench for i2s_frame_fifo with
// default parameters (24-bit samples, 8-frame FIFO). Define
// I2S_FRAME_FIFO_DROP_COUNT_EN to also check drop_count.
module tb_i2s_frame_fifo;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        sample_valid;
    logic [23:0] sample_data;
    logic        sample_lr;
    logic        frame_valid;
    logic        frame_ready;
    logic [23:0] frame_left;
    logic [23:0] frame_right;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        clear_overflow;
`ifdef I2S_FRAME_FIFO_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int errors = 0;
    int checks = 0;

    i2s_frame_fifo #(
        .I2S_WIDTH  (24),
        .FIFO_DEPTH (8)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .sample_lr      (sample_lr),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .frame_left     (frame_left),
        .frame_right    (frame_right),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef I2S_FRAME_FIFO_DROP_COUNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic lr, input logic [23:0] data);
        sample_valid = 1'b1;
        sample_lr    = lr;
        sample_data  = data;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send(1'b0, l);
        send(1'b1, r);
    endtask

    initial begin
        int sent;
        int received;

        sys_rst        = 1'b1;
        sample_valid   = 1'b1;
        sample_lr      = 1'b0;
        sample_data    = 24'hAA;
        frame_ready    = 1'b0;
        clear_overflow = 1'b0;
        tick();
        tick();
        sys_rst      = 1'b0;
        sample_valid = 1'b0;

        // reset state
        chk("rst_level", fifo_level, 0);
        chk("rst_valid", frame_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_left", frame_left, 0);
        chk("rst_right", frame_right, 0);

        // orphan right straight after reset: no frame
        send(1'b1, 24'h000002);
        chk("orphan_level", fifo_level, 0);
`ifdef I2S_FRAME_FIFO_DROP_COUNT_EN
        chk("orphan_dropcnt", drop_count, 1);
`endif

        // first frame, visible right after the R edge
        send_frame(24'h000001, 24'h000002);
        chk("first_valid", frame_valid, 1);
        chk("first_left", frame_left, 24'h000001);
        chk("first_right", frame_right, 24'h000002);
        chk("first_level", fifo_level, 1);

        // pop to empty, outputs hold
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk("pop_level", fifo_level, 0);
        chk("pop_valid", frame_valid, 0);
        chk("hold_left", frame_left, 24'h000001);
        chk("hold_right", frame_right, 24'h000002);

        // fill with 8, then a 9th that is dropped while clear_overflow is high
        for (int k = 1; k <= 8; k++) begin
            send_frame(24'h100 + 24'(k), 24'h200 + 24'(k));
        end
        chk("full_level", fifo_level, 8);
        chk("full_overflow", overflow, 0);
        send(1'b0, 24'h109);
        clear_overflow = 1'b1;
        send(1'b1, 24'h209);
        clear_overflow = 1'b0;
        chk("ovf_level", fifo_level, 8);
        chk("ovf_set_wins", overflow, 1);
        chk("ovf_head_left", frame_left, 24'h101);
        chk("ovf_head_right", frame_right, 24'h201);
`ifdef I2S_FRAME_FIFO_DROP_COUNT_EN
        chk("ovf_dropcnt_clr_inc", drop_count, 1);
`endif
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf_cleared", overflow, 0);
`ifdef I2S_FRAME_FIFO_DROP_COUNT_EN
        chk("dropcnt_cleared", drop_count, 0);
`endif

        // full FIFO: push coincident with pop is accepted
        send(1'b0, 24'h10A);
        frame_ready = 1'b1;
        send(1'b1, 24'h20A);
        frame_ready = 1'b0;
        chk("fullpp_level", fifo_level, 8);
        chk("fullpp_overflow", overflow, 0);
        chk("fullpp_head", frame_left, 24'h102);

        // drain: frames 2..8 then 10 (9 was dropped)
        frame_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int e;
            e = (i < 7) ? (i + 2) : 10;
            chk("drain_left", frame_left, 24'h100 + 24'(e));
            chk("drain_right", frame_right, 24'h200 + 24'(e));
            tick();
        end
        tick();
        frame_ready = 1'b0;
        chk("drain_empty_level", fifo_level, 0);
        chk("drain_empty_valid", frame_valid, 0);
        chk("drain_hold_left", frame_left, 24'h10A);

        // R, L=5, L=7, R=9 -> one frame {7,9}
        send(1'b1, 24'd3);
        send(1'b0, 24'd5);
        send(1'b0, 24'd7);
        send(1'b1, 24'd9);
        chk("resync_level", fifo_level, 1);
        chk("resync_left", frame_left, 24'd7);
        chk("resync_right", frame_right, 24'd9);
`ifdef I2S_FRAME_FIFO_DROP_COUNT_EN
        chk("resync_dropcnt", drop_count, 1);
`endif
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;

        // reset with 3 frames queued and a left sample pending
        send_frame(24'h21, 24'h41);
        send_frame(24'h22, 24'h42);
        send_frame(24'h23, 24'h43);
        send(1'b0, 24'h2F);
        chk("pre_rst_level", fifo_level, 3);
        sys_rst      = 1'b1;
        sample_valid = 1'b1;
        sample_lr    = 1'b1;
        sample_data  = 24'h3F;
        tick();
        sys_rst      = 1'b0;
        sample_valid = 1'b0;
        chk("midrst_level", fifo_level, 0);
        chk("midrst_valid", frame_valid, 0);
        chk("midrst_left", frame_left, 0);
        chk("midrst_right", frame_right, 0);
        send(1'b1, 24'h55);
        chk("midrst_waitl", fifo_level, 0);
        send_frame(24'h31, 24'h32);
        chk("fresh_level", fifo_level, 1);
        chk("fresh_left", frame_left, 24'h31);
        chk("fresh_right", frame_right, 24'h32);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk("fresh_pop", fifo_level, 0);

        // stream 20 frames with frame_ready toggling every cycle
        sent     = 0;
        received = 0;
        for (int c = 0; c < 200 && received < 20; c++) begin
            if (sent < 40) begin
                sample_valid = 1'b1;
                sample_lr    = sent[0];
                sample_data  = sent[0] ? (24'h800 + 24'(sent / 2)) : (24'h400 + 24'(sent / 2));
                sent++;
            end else begin
                sample_valid = 1'b0;
            end
            frame_ready = c[0];
            if (frame_valid && frame_ready) begin
                chk("stream_left", frame_left, 24'h400 + 24'(received));
                chk("stream_right", frame_right, 24'h800 + 24'(received));
                received++;
            end
            tick();
        end
        sample_valid = 1'b0;
        frame_ready  = 1'b0;
        chk("stream_count", received, 20);
        chk("stream_overflow", overflow, 0);
        chk("stream_level", fifo_level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_frame_fifo.md
I2S_FRAME_FIFO -- requirements
Module: i2s_frame_fifo

Interface
REQ-001 SHALL provide parameter I2S_WIDTH, default 24: sample width in bits.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 8: stereo frames stored; power of two, >= 2.
REQ-003 SHALL have port sys_clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe: a new sample is on sample_data.
REQ-006 SHALL have port sample_data  input  I2S_WIDTH  received sample, two's complement.
REQ-007 SHALL have port sample_lr  input  1  channel of sample_data: 0 = left, 1 = right.
REQ-008 SHALL have port frame_valid  output  1  head frame available.
REQ-009 SHALL have port frame_ready  input  1  consumer accepts the head frame.
REQ-010 SHALL have port frame_left  output  I2S_WIDTH  head frame left sample.
REQ-011 SHALL have port frame_right  output  I2S_WIDTH  head frame right sample.
REQ-012 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  number of stored frames.
REQ-013 SHALL have port overflow  output  1  sticky: a frame was dropped.
REQ-014 SHALL have port clear_overflow  input  1  clears overflow.

Function
REQ-015 Pairing FSM SHALL have states WAIT_L and WAIT_R.
REQ-016 WAIT_L, sample_valid and sample_lr=0: latch sample as left, go to WAIT_R.
REQ-017 WAIT_L, sample_valid and sample_lr=1: discard the orphan right sample, stay in WAIT_L.
REQ-018 WAIT_R, sample_valid and sample_lr=1: form frame {left latch, sample_data}, request push, go to WAIT_L.
REQ-019 WAIT_R, sample_valid and sample_lr=0: overwrite left latch, stay in WAIT_R (resync; no frame formed).
REQ-020 Push SHALL be accepted when fifo_level < FIFO_DEPTH, or when fifo_level = FIFO_DEPTH and a pop occurs in the same cycle.
REQ-021 A rejected push SHALL drop the whole frame and set overflow on the next edge; FIFO contents SHALL be unchanged.
REQ-022 Pop SHALL occur when frame_valid and frame_ready are both high; frame_ready while empty SHALL be ignored.
REQ-023 Output SHALL be first-word-fall-through: frame_valid = (fifo_level != 0); frame_left/frame_right show the head frame.
REQ-024 Latency: for a frame pushed on edge N (the right-sample cycle) into an empty FIFO, frame_valid SHALL be high after edge N.
REQ-025 A simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; frames SHALL emerge in push order.
REQ-027 frame_left/frame_right SHALL hold their last value while frame_valid is low.
REQ-028 If clear_overflow and a new drop occur in the same cycle, overflow SHALL be 1 (set wins).

Reset
REQ-029 sys_rst SHALL set the FSM to WAIT_L and clear the left latch and both pointers.
REQ-030 After reset: fifo_level=0, frame_valid=0, overflow=0, frame_left=0, frame_right=0.
REQ-031 Reset asserted mid-frame or with the FIFO non-empty SHALL discard all stored and partial data; sample_valid during reset SHALL be ignored.

Configuration
REQ-032 Macro I2S_FRAME_FIFO_DROP_COUNT_EN, when defined, SHALL add output drop_count (16 bits).
REQ-033 drop_count SHALL count rejected frames plus orphan right samples (REQ-017), saturating at 16'hFFFF.
REQ-034 drop_count SHALL be cleared by sys_rst and by clear_overflow; an increment in the same cycle as clear_overflow SHALL yield 1.
REQ-035 Without the macro, drop_count and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 Reset, then L=24'h000001, R=24'h000002, frame_ready=0 -> frame_valid=1 one cycle after the R strobe, frame_left=1, frame_right=2, fifo_level=1.
REQ-037 Push 9 frames with FIFO_DEPTH=8 and frame_ready=0 -> fifo_level=8, overflow=1, 9th frame absent; drain yields frames 1-8 in order.
REQ-038 Full FIFO, push coincident with frame_ready=1 -> push accepted, fifo_level stays 8, overflow stays 0.
REQ-039 Sequence R, L=5, L=7, R=9 -> single frame {7,9}; with I2S_FRAME_FIFO_DROP_COUNT_EN defined, drop_count=1.
REQ-040 Assert sys_rst for one cycle with 3 frames queued and FSM in WAIT_R -> fifo_level=0, frame_valid=0; next L/R pair forms a fresh frame.
REQ-041 Stream 20 frames with frame_ready toggling every cycle -> all 20 frames out in order, pointers wrap, overflow=0.
